store_rmw_controller: RTL and testbench
=======================================

Name: store_rmw_controller

Overview:
Sequences sub-word stores (sb/sh) and full-word stores (sw) against the word-organised data memory. Sub-word stores use a read-modify-write: read the word, merge the new byte or halfword into the addressed lane, write the word back. Sits between the MEM stage store request and the data memory port. The pipeline stalls on Busy.

Parameters:
ADDR_W, 32, byte address width; memory word address is ADDR_W-2 bits.
RD_LAT, 1, memory read latency in cycles from the MemRd cycle to valid MemRData; legal range 1..4.

Ports:
Clk  in  1  rising-edge clock
Rst  in  1  asynchronous reset, active-low
Req  in  1  store request; sampled only in IDLE
Size  in  2  00 byte, 01 halfword, 10 word, 11 reserved
Addr  in  ADDR_W  byte address (offset + base)
WData  in  32  register data; store source is [7:0], [15:0] or [31:0]
Busy  out  1  high in every state except IDLE
Done  out  1  one-cycle completion pulse
Err  out  1  valid only with Done; 1 = misaligned or reserved Size, no memory access made
MemAddr  out  ADDR_W-2  word address = latched Addr[ADDR_W-1:2]
MemRd  out  1  one-cycle read strobe
MemRData  in  32  read data
MemWr  out  1  one-cycle write strobe
MemWData  out  32  merged write word

Behaviour:
- Reset (Rst=0, asynchronous): state IDLE; Busy, Done, Err, MemRd, MemWr = 0; MemAddr = 0; MemWData = 0; latched request and wait counter cleared. A reset during READ, WAIT or WRITE aborts the store. MemWr drops immediately. No partial write completes after reset.
- Acceptance: in IDLE with Req=1, latch Addr, Size and WData. Later input changes have no effect. Req while Busy=1 is ignored; the requester must hold Req until Busy falls.
- Lane mapping is little-endian. Byte lane n = bits [8n+7:8n] for Addr[1:0]=n. Halfword: Addr[1]=0 writes [15:0], Addr[1]=1 writes [31:16].
- Error check at acceptance: Size=11, or Size=01 with Addr[0]=1, or Size=10 with Addr[1:0]!=00. On error go IDLE->DONE with Err=1; MemRd and MemWr stay 0.
- States:
  - IDLE: Busy=0. Word store goes to WRITE. Byte or half store goes to READ. Error goes to DONE.
  - READ: MemRd=1 for exactly one cycle. Load the wait counter with RD_LAT. Go to WAIT.
  - WAIT: decrement the counter each cycle. On the cycle the counter reaches 1, capture MemRData, compute the merged word into MemWData, and go to WRITE. WAIT lasts exactly RD_LAT cycles.
  - WRITE: MemWr=1 for exactly one cycle. MemWData holds the merged word, or the latched WData for a word store. Go to DONE.
  - DONE: Done=1 for one cycle. Err is driven as decided at acceptance. Go to IDLE. A Req in the DONE cycle is not accepted.
- Merge: only the addressed lane(s) take the new data. All other bits come from the captured MemRData unchanged.
- Latency from the Req-accept edge to Done, including the IDLE acceptance cycle:
  - word: 3 cycles
  - sub-word: 4+RD_LAT cycles
  - error: 2 cycles
- MemAddr updates on acceptance and is held stable through READ, WAIT and WRITE. It retains its value in IDLE.
- MemRd and MemWr are never high in the same cycle. Each is asserted at most once per request.

Test Plan:
- Byte store, RD_LAT=1: memory word at 0x40 = 0xAABBCCDD; Req, Size=00, Addr=0x41, WData=0x00000011 -> MemRd pulse with MemAddr=0x10; MemWr pulse with MemWData=0xAABB11DD; Done 5 cycles after accept, Err=0.
- Half store, upper half: word = 0x12345678; Size=01, Addr=0x42, WData=0x0000BEEF -> MemWData=0xBEEF5678. Repeat with RD_LAT=3 -> Done 7 cycles after accept.
- Word store: Size=10, Addr=0x80, WData=0xDEADBEEF -> no MemRd; MemWr with MemAddr=0x20, MemWData=0xDEADBEEF; Done 3 cycles after accept.
- Errors: Size=01, Addr=0x43 -> Done with Err=1 2 cycles after accept, no MemRd or MemWr; Size=11 -> same response.
- Busy handling: second Req held high through the first store -> accepted only in the IDLE cycle after Done. Inputs changed mid-operation -> write data unaffected.
- Reset during WAIT (Rst low for 1 cycle) -> all outputs 0 immediately, MemWr never asserted; the next Req completes normally.

Source files
------------

// File: rtl/store_rmw_controller.sv
// Store sequencer in front of a word-organised data memory: sw writes directly,
// sb/sh read the word, merge the new lane(s) and write it back.
module store_rmw_controller #(
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Req,
  input  logic [1:0]        Size,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [31:0]       WData,
  output logic              Busy,
  output logic              Done,
  output logic              Err,
  output logic [ADDR_W-3:0] MemAddr,
  output logic              MemRd,
  input  logic [31:0]       MemRData,
  output logic              MemWr,
  output logic [31:0]       MemWData,
  output logic [2:0]        o_dbg_state
);

  // Handshake: Req is sampled only while Busy=0 (IDLE); a sampled Req is the
  // accept. Busy stays high until the Done cycle has passed.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [2:0] LAT_LOAD = 3'(RD_LAT);

  state_t            r_state;
  state_t            w_next;
  logic [1:0]        r_size;
  logic [1:0]        r_lane;
  logic [31:0]       r_wdata;
  logic              r_err;
  logic [2:0]        r_cnt;
  logic [ADDR_W-3:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;

  logic              w_err;
  logic              w_accept;
  logic              w_wait_last;
  logic [31:0]       w_merged;

  assign w_err = (Size == 2'b11) ||
                 ((Size == SZ_HALF) && Addr[0]) ||
                 ((Size == SZ_WORD) && (Addr[1:0] != 2'b00));

  assign w_accept    = (r_state == S_IDLE) && Req;
  assign w_wait_last = (r_state == S_WAIT) && (r_cnt <= 3'd1);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (Req) begin
          if (w_err)                w_next = S_DONE;
          else if (Size == SZ_WORD) w_next = S_WRITE;
          else                      w_next = S_READ;
        end
      end
      S_READ:  w_next = S_WAIT;
      S_WAIT:  if (w_wait_last) w_next = S_WRITE;
      S_WRITE: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Little-endian lane merge; untouched lanes pass the read word through.
  always_comb begin
    w_merged = MemRData;
    case (r_size)
      SZ_BYTE: begin
        case (r_lane)
          2'd0:    w_merged[7:0]   = r_wdata[7:0];
          2'd1:    w_merged[15:8]  = r_wdata[7:0];
          2'd2:    w_merged[23:16] = r_wdata[7:0];
          default: w_merged[31:24] = r_wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        if (r_lane[1]) w_merged[31:16] = r_wdata[15:0];
        else           w_merged[15:0]  = r_wdata[15:0];
      end
      default: w_merged = MemRData;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_size      <= 2'b00;
      r_lane      <= 2'b00;
      r_wdata     <= 32'd0;
      r_err       <= 1'b0;
      r_cnt       <= 3'd0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 32'd0;
    end else begin
      if (w_accept) begin
        r_size     <= Size;
        r_lane     <= Addr[1:0];
        r_wdata    <= WData;
        r_err      <= w_err;
        r_mem_addr <= Addr[ADDR_W-1:2];
        if (!w_err && (Size == SZ_WORD)) r_mem_wdata <= WData;
      end
      if (r_state == S_READ) r_cnt <= LAT_LOAD;
      else if (r_state == S_WAIT) r_cnt <= r_cnt - 3'd1;
      if (w_wait_last) r_mem_wdata <= w_merged;
    end
  end

  assign Busy        = (r_state != S_IDLE);
  assign Done        = (r_state == S_DONE);
  assign Err         = (r_state == S_DONE) && r_err;
  assign MemRd       = (r_state == S_READ);
  assign MemWr       = (r_state == S_WRITE);
  assign MemAddr     = r_mem_addr;
  assign MemWData    = r_mem_wdata;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_store_rmw_controller.sv
// Two controllers (read latency 1 and 3) against a memory model and a per-cycle
// expected-output trace derived from the store rules.
module tb_store_rmw_controller;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        Rst;
  logic        req    [2];
  logic [1:0]  size   [2];
  logic [31:0] addr   [2];
  logic [31:0] wdata  [2];
  logic        busy   [2];
  logic        done   [2];
  logic        err    [2];
  logic        mrd    [2];
  logic        mwr    [2];
  logic [29:0] maddr  [2];
  logic [31:0] mrdata [2];
  logic [31:0] mwdata [2];
  logic [2:0]  dbg    [2];
  logic        poke_en[2];
  logic [5:0]  poke_a [2];
  logic [31:0] poke_d [2];

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        err;
    logic        rd;
    logic        wr;
    logic [31:0] wd;
  } exp_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic b, input logic d, input logic e,
                              input logic r, input logic w, input logic [31:0] wd);
    return exp_t'({b, d, e, r, w, wd});
  endfunction

  function automatic bit is_err(input logic [1:0] s, input logic [31:0] a);
    return (s == 2'b11) || (s == 2'b01 && a[0]) || (s == 2'b10 && a[1:0] != 2'b00);
  endfunction

  function automatic int exp_lat(input int d, input logic [1:0] s, input logic [31:0] a);
    if (is_err(s, a)) return 2;
    if (s == 2'b10) return 3;
    return 4 + ((d == 0) ? 1 : 3);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int LAT = (g == 0) ? 1 : 3;

    store_rmw_controller #(.ADDR_W(32), .RD_LAT(LAT)) dut (
      .Clk(Clk), .Rst(Rst), .Req(req[g]), .Size(size[g]), .Addr(addr[g]),
      .WData(wdata[g]), .Busy(busy[g]), .Done(done[g]), .Err(err[g]),
      .MemAddr(maddr[g]), .MemRd(mrd[g]), .MemRData(mrdata[g]), .MemWr(mwr[g]),
      .MemWData(mwdata[g]), .o_dbg_state(dbg[g])
    );

    // Memory: data appears exactly LAT cycles after the read strobe, noise otherwise.
    logic [31:0] mem [64];
    int          pend;
    logic [5:0]  pend_a;
    logic [31:0] garbage;

    always @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
        pend <= 0;
      end else begin
        garbage <= $urandom;
        if (mrd[g]) begin
          pend   <= LAT;
          pend_a <= maddr[g][5:0];
        end else if (pend > 0) begin
          pend <= pend - 1;
        end
        if (mwr[g]) mem[maddr[g][5:0]] <= mwdata[g];
        else if (poke_en[g]) mem[poke_a[g]] <= poke_d[g];
      end
    end

    assign mrdata[g] = (pend == 1) ? mem[pend_a] : garbage;

    // Reference: on accept, push the whole expected output trace of the store.
    logic [31:0] ref_mem [64];
    exp_t        q[$];
    exp_t        cur;
    logic [29:0] m_addr;
    logic [31:0] mask, nw;
    logic [5:0]  idx;
    int          sh;

    always @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
        q.delete();
        cur    = '0;
        m_addr = '0;
      end else begin
        if (poke_en[g]) ref_mem[poke_a[g]] = poke_d[g];
        if (!cur.busy && req[g]) begin
          idx    = addr[g][7:2];
          m_addr = addr[g][31:2];
          if (is_err(size[g], addr[g])) begin
            q.push_back(mk(1, 1, 1, 0, 0, 0));
          end else if (size[g] == 2'b10) begin
            q.push_back(mk(1, 0, 0, 0, 1, wdata[g]));
            q.push_back(mk(1, 1, 0, 0, 0, 0));
            ref_mem[idx] = wdata[g];
          end else begin
            if (size[g] == 2'b00) begin
              sh   = 8 * int'(addr[g][1:0]);
              mask = 32'h0000_00FF << sh;
              nw   = (ref_mem[idx] & ~mask) | ((wdata[g] & 32'h0000_00FF) << sh);
            end else begin
              sh   = 16 * int'(addr[g][1]);
              mask = 32'h0000_FFFF << sh;
              nw   = (ref_mem[idx] & ~mask) | ((wdata[g] & 32'h0000_FFFF) << sh);
            end
            q.push_back(mk(1, 0, 0, 1, 0, 0));
            repeat (LAT) q.push_back(mk(1, 0, 0, 0, 0, 0));
            q.push_back(mk(1, 0, 0, 0, 1, nw));
            q.push_back(mk(1, 1, 0, 0, 0, 0));
            ref_mem[idx] = nw;
          end
        end
        cur = (q.size() > 0) ? q.pop_front() : '0;
      end
    end

    always @(negedge Clk) begin
      if (Rst === 1'b1) begin
        check($sformatf("i%0d busy", g),  32'(busy[g]),  32'(cur.busy));
        check($sformatf("i%0d done", g),  32'(done[g]),  32'(cur.done));
        check($sformatf("i%0d memrd", g), 32'(mrd[g]),   32'(cur.rd));
        check($sformatf("i%0d memwr", g), 32'(mwr[g]),   32'(cur.wr));
        check($sformatf("i%0d maddr", g), 32'(maddr[g]), 32'(m_addr));
        if (cur.done) check($sformatf("i%0d err", g), 32'(err[g]), 32'(cur.err));
        if (cur.wr) check($sformatf("i%0d mwdata", g), mwdata[g], cur.wd);
      end
    end
  end

  task automatic poke(input int d, input logic [5:0] a, input logic [31:0] v);
    @(negedge Clk); #1;
    poke_en[d] = 1'b1; poke_a[d] = a; poke_d[d] = v;
    @(posedge Clk); #1;
    poke_en[d] = 1'b0;
  endtask

  task automatic store(input int d, input logic [1:0] s, input logic [31:0] a,
                       input logic [31:0] w, input bit hold, output int lat, output logic e);
    @(negedge Clk); #1;
    req[d] = 1'b1; size[d] = s; addr[d] = a; wdata[d] = w;
    lat = 0;
    e   = 1'b0;
    if (!hold) begin
      @(posedge Clk); #1;
      req[d] = 1'b0; size[d] = 2'($urandom_range(0, 3)); addr[d] = $urandom; wdata[d] = $urandom;
    end
    for (int n = 1; n <= 20; n++) begin
      @(negedge Clk);
      if (done[d]) begin
        lat = n + 1;
        e   = err[d];
        break;
      end
    end
    if (lat == 0) check($sformatf("i%0d done timeout", d), 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, lat2;
    logic        e, e2;
    int          d;
    logic [1:0]  s;
    logic [31:0] a, w;
    bit          hold;

    Rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; size[i] = 2'b00; addr[i] = 32'd0; wdata[i] = 32'd0;
      poke_en[i] = 1'b0; poke_a[i] = 6'd0; poke_d[i] = 32'd0;
    end
    #2;
    check("reset busy",   32'(busy[0]),  32'd0);
    check("reset done",   32'(done[0]),  32'd0);
    check("reset memrd",  32'(mrd[1]),   32'd0);
    check("reset memwr",  32'(mwr[1]),   32'd0);
    check("reset maddr",  32'(maddr[0]), 32'd0);
    check("reset mwdata", mwdata[1],     32'd0);
    @(negedge Clk); #1;
    Rst = 1'b1;

    for (int i = 0; i < 64; i++) begin
      poke(0, 6'(i), $urandom);
      poke(1, 6'(i), $urandom);
    end

    poke(0, 6'h10, 32'hAABBCCDD);
    store(0, 2'b00, 32'h41, 32'h0000_0011, 0, lat, e);
    check("sb lat", 32'(lat), 32'd5);
    check("sb err", 32'(e), 32'd0);
    check("sb word", inst[0].mem[16], 32'hAABB11DD);

    poke(0, 6'h10, 32'h12345678);
    store(0, 2'b01, 32'h42, 32'h0000_BEEF, 0, lat, e);
    check("sh lat1", 32'(lat), 32'd5);
    check("sh word1", inst[0].mem[16], 32'hBEEF5678);
    poke(1, 6'h10, 32'h12345678);
    store(1, 2'b01, 32'h42, 32'h0000_BEEF, 0, lat, e);
    check("sh lat3", 32'(lat), 32'd7);
    check("sh word3", inst[1].mem[16], 32'hBEEF5678);

    store(0, 2'b10, 32'h80, 32'hDEADBEEF, 0, lat, e);
    check("sw lat", 32'(lat), 32'd3);
    check("sw word", inst[0].mem[32], 32'hDEADBEEF);

    poke(0, 6'h10, 32'h55AA55AA);
    store(0, 2'b01, 32'h43, 32'h0000_1234, 0, lat, e);
    check("misalign lat", 32'(lat), 32'd2);
    check("misalign err", 32'(e), 32'd1);
    store(0, 2'b11, 32'h40, 32'h0000_1234, 0, lat, e);
    check("size11 lat", 32'(lat), 32'd2);
    check("size11 err", 32'(e), 32'd1);
    check("err no write", inst[0].mem[16], 32'h55AA55AA);

    poke(0, 6'h11, 32'h01020304);
    store(0, 2'b00, 32'h44, 32'h0000_00A5, 1, lat, e);
    store(0, 2'b10, 32'h48, 32'hCAFEF00D, 0, lat2, e2);
    check("hold lat a", 32'(lat), 32'd5);
    check("hold lat b", 32'(lat2), 32'd3);
    check("hold word a", inst[0].mem[17], 32'h010203A5);
    check("hold word b", inst[0].mem[18], 32'hCAFEF00D);

    poke(1, 6'h14, 32'h11223344);
    @(negedge Clk); #1;
    req[1] = 1'b1; size[1] = 2'b00; addr[1] = 32'h50; wdata[1] = 32'h0000_00FF;
    @(posedge Clk); #1;
    req[1] = 1'b0;
    @(posedge Clk);
    @(negedge Clk); #1;
    Rst = 1'b0;
    #1;
    check("rst busy",   32'(busy[1]),  32'd0);
    check("rst done",   32'(done[1]),  32'd0);
    check("rst memrd",  32'(mrd[1]),   32'd0);
    check("rst memwr",  32'(mwr[1]),   32'd0);
    check("rst maddr",  32'(maddr[1]), 32'd0);
    check("rst mwdata", mwdata[1],     32'd0);
    @(negedge Clk); #1;
    Rst = 1'b1;
    repeat (8) @(negedge Clk);
    check("rst no write", inst[1].mem[20], 32'h11223344);
    store(1, 2'b00, 32'h50, 32'h0000_00FF, 0, lat, e);
    check("post rst lat", 32'(lat), 32'd7);
    check("post rst word", inst[1].mem[20], 32'h112233FF);

    for (int it = 0; it < 150; it++) begin
      d    = $urandom_range(0, 1);
      s    = 2'($urandom_range(0, 3));
      a    = 32'($urandom_range(0, 255));
      w    = $urandom;
      hold = 1'($urandom_range(0, 1));
      poke(d, a[7:2], $urandom);
      store(d, s, a, w, hold, lat, e);
      check("rand lat", 32'(lat), 32'(exp_lat(d, s, a)));
      check("rand err", 32'(e), 32'(is_err(s, a)));
      if (hold) begin
        s = 2'($urandom_range(0, 3));
        a = 32'($urandom_range(0, 255));
        w = $urandom;
        store(d, s, a, w, 0, lat, e);
        check("chain lat", 32'(lat), 32'(exp_lat(d, s, a)));
        check("chain err", 32'(e), 32'(is_err(s, a)));
      end
    end

    repeat (4) @(negedge Clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
